// File: rtl/analog_io_sequencer.sv
// Break-before-make sequencer for analog/digital I/O pad channels.
// Optional lock feature: define ANALOG_IO_LOCK_EN to add cfg_lock/locked.
module analog_io_sequencer #(
  parameter int BITS          = 6,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(BITS)-1:0] cfg_chan,
  input  logic [1:0]              cfg_mode,
  input  logic [BITS-1:0]         dig_in,
  output logic [BITS-1:0]         io_out,
  output logic [BITS-1:0]         io_oeb,
  output logic                    busy,
  output logic                    cfg_err
`ifdef ANALOG_IO_LOCK_EN
  ,
  input  logic                    cfg_lock,
  output logic                    locked
`endif
);

  localparam int CW = $clog2(BITS);

  typedef enum logic {IDLE, RELEASE} state_t;

  state_t                  state, state_d;
  logic [7:0]              cnt;
  logic [BITS-1:0][1:0]    mode, mode_d;
  logic [CW-1:0]           chan, force_ch;
  logic [1:0]              tgt;
  logic [BITS-1:0]         out_d, oeb_d;
  logic                    accept, illegal, change;
  logic                    lock_block, force_on, done;

  assign accept  = cfg_valid & cfg_ready;
  assign illegal = ({1'b0, cfg_chan} >= (CW+1)'(BITS)) | lock_block;
  assign change  = accept & ~illegal & (cfg_mode != mode[cfg_chan]);
  assign done    = (state == RELEASE) & (cnt == 8'd0);

`ifdef ANALOG_IO_LOCK_EN
  assign lock_block = locked;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)
      locked <= 1'b0;
    else if (accept && cfg_lock)
      locked <= 1'b1;
  end
`else
  assign lock_block = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (change) state_d = RELEASE;
      RELEASE: if (cnt == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    unique case (1'b1)
      (state == IDLE): cfg_ready = 1'b1;
      default:         cfg_ready = 1'b0;
    endcase
    busy = ~cfg_ready;
  end

  // Target is held parked (oeb=1,out=1) from acceptance until the mode commits.
  always_comb begin
    mode_d = mode;
    if (done)
      mode_d[chan] = tgt;
    force_on = change | ((state == RELEASE) & (cnt != 8'd0));
    force_ch = change ? cfg_chan : chan;
    out_d    = '1;
    oeb_d    = '1;
    for (int i = 0; i < BITS; i++) begin
      unique case (mode_d[i])
        2'b00: begin out_d[i] = 1'b1;      oeb_d[i] = 1'b1; end
        2'b01: begin out_d[i] = 1'b0;      oeb_d[i] = 1'b0; end
        2'b10: begin out_d[i] = 1'b1;      oeb_d[i] = 1'b0; end
        default: begin out_d[i] = dig_in[i]; oeb_d[i] = 1'b0; end
      endcase
      if (force_on && force_ch == CW'(i)) begin
        out_d[i] = 1'b1;
        oeb_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      mode    <= '0;
      cnt     <= 8'd0;
      chan    <= '0;
      tgt     <= 2'b00;
      cfg_err <= 1'b0;
      io_out  <= '1;
      io_oeb  <= '1;
    end else begin
      cfg_err <= accept & illegal;
      mode    <= mode_d;
      io_out  <= out_d;
      io_oeb  <= oeb_d;
      if (change) begin
        chan <= cfg_chan;
        tgt  <= cfg_mode;
        cnt  <= 8'(SETTLE_CYCLES - 1);
      end else if (state == RELEASE && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_analog_io_sequencer.sv
// Random and directed checks of analog_io_sequencer against a
// timeline-based reference model (default build, lock feature off).
module tb_analog_io_sequencer;

  localparam int BITS = 6;
  localparam int S    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2:0]      cfg_chan;
  logic [1:0]      cfg_mode;
  logic [BITS-1:0] dig_in;
  logic [BITS-1:0] io_out;
  logic [BITS-1:0] io_oeb;
  logic            busy;
  logic            cfg_err;

  int checks = 0;
  int errors = 0;

  analog_io_sequencer #(.BITS(BITS), .SETTLE_CYCLES(S)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_mode (cfg_mode),
    .dig_in   (dig_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: modes per channel plus one pending sequence timeline.
  logic [1:0] m [BITS];
  int         n;
  bit         act;
  int         k;
  int         tch;
  logic [1:0] tmd;
  bit         err_e;
  bit         last_acc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < BITS; i++) m[i] = 2'b00;
    act   = 1'b0;
    err_e = 1'b0;
  endtask

  task automatic check_outputs();
    logic [BITS-1:0] eo, ee;
    for (int i = 0; i < BITS; i++) begin
      if (act && i == tch) begin
        eo[i] = 1'b1; ee[i] = 1'b1;
      end else begin
        case (m[i])
          2'b00: begin eo[i] = 1'b1; ee[i] = 1'b1; end
          2'b01: begin eo[i] = 1'b0; ee[i] = 1'b0; end
          2'b10: begin eo[i] = 1'b1; ee[i] = 1'b0; end
          default: begin eo[i] = dig_in[i]; ee[i] = 1'b0; end
        endcase
      end
    end
    chk("io_out", 32'(io_out), 32'(eo));
    chk("io_oeb", 32'(io_oeb), 32'(ee));
    chk("cfg_ready", 32'(cfg_ready), 32'(!act));
    chk("busy", 32'(busy), 32'(act));
    chk("cfg_err", 32'(cfg_err), 32'(err_e));
  endtask

  // Called just after a negedge; drives inputs, steps one edge, checks.
  task automatic step(input bit v, input int ch, input logic [1:0] md);
    bit rdy;
    cfg_valid = v;
    cfg_chan  = 3'(ch);
    cfg_mode  = md;
    dig_in    = BITS'($urandom);
    @(posedge clk);
    n++;
    rdy = !act;
    if (act && n == k + S) begin
      m[tch] = tmd;
      act    = 1'b0;
    end
    last_acc = v && rdy;
    err_e    = 1'b0;
    if (last_acc) begin
      if (ch >= BITS) err_e = 1'b1;
      else if (md != m[ch]) begin
        act = 1'b1; k = n; tch = ch; tmd = md;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 0, 2'b00);
  endtask

  initial begin
    bit         pv;
    int         pch;
    logic [1:0] pmd;
    n = 0;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan = '0;
    cfg_mode = '0;
    dig_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_out", 32'(io_out), 32'h3F);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();

    // Drive chan 2 to 1, then 1 -> 0 transition, then illegal/same-mode.
    step(1'b1, 2, 2'b10);
    idle(S + 1);
    chk("ch2_drive1_oeb", 32'(io_oeb[2]), 32'd0);
    step(1'b1, 2, 2'b01);
    idle(S + 1);
    chk("ch2_drive0_out", 32'(io_out[2]), 32'd0);
    step(1'b1, 7, 2'b11);
    chk("illegal_err", 32'(cfg_err), 32'd1);
    idle(1);
    step(1'b1, 2, 2'b01);
    chk("same_mode_ready", 32'(cfg_ready), 32'd1);
    idle(2);

    // Reset in the middle of a sequence on chan 0.
    step(1'b1, 0, 2'b11);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("abort_out", 32'(io_out), 32'h3F);
    chk("abort_oeb", 32'(io_oeb), 32'h3F);
    chk("abort_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(S + 2);
    chk("abort_ch0_oeb", 32'(io_oeb[0]), 32'd1);

    // Random requests; requester holds each until accepted.
    pv = 1'b0; pch = 0; pmd = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if (!pv && ($urandom_range(0, 1) == 1)) begin
        pv  = 1'b1;
        pch = $urandom_range(0, 7);
        pmd = 2'($urandom);
      end
      step(pv, pch, pmd);
      if (last_acc) pv = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
